// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU: alu_op encodings and FSM states.
// Used by both build variants (MULTICYCLE_ALU_FAST_SHIFT_EN defined or not).
package multicycle_alu_pkg;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_SUB = 4'd1;
    localparam logic [3:0] ALU_OP_SLL = 4'd2;
    localparam logic [3:0] ALU_OP_XOR = 4'd3;
    localparam logic [3:0] ALU_OP_OR  = 4'd4;
    localparam logic [3:0] ALU_OP_AND = 4'd5;
    localparam logic [3:0] ALU_OP_SRL = 4'd6;
    localparam logic [3:0] ALU_OP_BEQ = 4'd7;
    localparam logic [3:0] ALU_OP_BNE = 4'd8;
    localparam logic [3:0] ALU_OP_BLT = 4'd9;
    localparam logic [3:0] ALU_OP_BGE = 4'd10;

    typedef enum logic [1:0] {
        ALU_ST_IDLE  = 2'd0,
        ALU_ST_SHIFT = 2'd1,
        ALU_ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL);
    endfunction

endpackage

// File: rtl/multicycle_alu_comb.sv
// One-cycle ALU datapath: arithmetic, logic and branch compare. With MULTICYCLE_ALU_FAST_SHIFT_EN
// it also holds the barrel shifter; otherwise shift ops pass operand 1 through for the serial loop.
module alu_comb
    import multicycle_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_in_1,
    input  logic [DATA_WIDTH-1:0] alu_in_2,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  alu_bcond
);

    logic [DATA_WIDTH-1:0] w_diff;

    assign w_diff = alu_in_1 - alu_in_2;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        alu_result = '0;
        alu_bcond  = 1'b0;
        case (alu_op)
            ALU_OP_ADD: alu_result = alu_in_1 + alu_in_2;
            ALU_OP_SUB: alu_result = w_diff;
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
            ALU_OP_SLL: alu_result = alu_in_1 << alu_in_2[SHAMT_WIDTH-1:0];
            ALU_OP_SRL: alu_result = alu_in_1 >> alu_in_2[SHAMT_WIDTH-1:0];
`else
            ALU_OP_SLL,
            ALU_OP_SRL: alu_result = alu_in_1;
`endif
            ALU_OP_XOR: alu_result = alu_in_1 ^ alu_in_2;
            ALU_OP_OR:  alu_result = alu_in_1 | alu_in_2;
            ALU_OP_AND: alu_result = alu_in_1 & alu_in_2;
            ALU_OP_BEQ: begin
                alu_result = w_diff;
                alu_bcond  = (alu_in_1 == alu_in_2);
            end
            ALU_OP_BNE: begin
                alu_result = w_diff;
                alu_bcond  = (alu_in_1 != alu_in_2);
            end
            ALU_OP_BLT: begin
                alu_result = w_diff;
                alu_bcond  = ($signed(alu_in_1) < $signed(alu_in_2));
            end
            ALU_OP_BGE: begin
                alu_result = w_diff;
                alu_bcond  = ($signed(alu_in_1) >= $signed(alu_in_2));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Iterative execute-stage ALU with valid/ready handshakes. Logical shifts run one bit per cycle
// unless MULTICYCLE_ALU_FAST_SHIFT_EN is defined, in which case every op takes one cycle.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_in_1,
    input  logic [DATA_WIDTH-1:0] alu_in_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  alu_bcond
);

    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_bcond;

    alu_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_bcond;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
    logic [3:0]            r_op;
    logic [SHAMT_WIDTH-1:0] r_cnt;
`endif

    alu_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_WIDTH(SHAMT_WIDTH)
    ) u_alu_comb (
        .alu_op    (alu_op),
        .alu_in_1  (alu_in_1),
        .alu_in_2  (alu_in_2),
        .alu_result(w_result),
        .alu_bcond (w_bcond)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ALU_ST_IDLE;
            r_result <= '0;
            r_bcond  <= 1'b0;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
            r_op     <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ALU_ST_IDLE: begin
                    if (in_valid) begin
                        r_result <= w_result;
                        r_bcond  <= w_bcond;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
                        r_op     <= alu_op;
                        r_cnt    <= alu_in_2[SHAMT_WIDTH-1:0];
                        // Shift by zero needs no iterations; the pass-through result is already final.
                        if (is_shift_op(alu_op) && (alu_in_2[SHAMT_WIDTH-1:0] != '0))
                            r_state <= ALU_ST_SHIFT;
                        else
                            r_state <= ALU_ST_DONE;
`else
                        r_state  <= ALU_ST_DONE;
`endif
                    end
                end
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
                ALU_ST_SHIFT: begin
                    if (r_op == ALU_OP_SLL)
                        r_result <= {r_result[DATA_WIDTH-2:0], 1'b0};
                    else
                        r_result <= {1'b0, r_result[DATA_WIDTH-1:1]};
                    r_cnt <= r_cnt - SHAMT_WIDTH'(1);
                    if (r_cnt == SHAMT_WIDTH'(1))
                        r_state <= ALU_ST_DONE;
                end
`endif
                ALU_ST_DONE: begin
                    if (out_ready)
                        r_state <= ALU_ST_IDLE;
                end
                default: r_state <= ALU_ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == ALU_ST_IDLE);
    assign out_valid  = (r_state == ALU_ST_DONE);
    assign alu_result = r_result;
    assign alu_bcond  = r_bcond;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against a cycle-count reference model;
// honours MULTICYCLE_ALU_FAST_SHIFT_EN when computing expected latency.
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = '0;
    logic [31:0] alu_in_1 = '0;
    logic [31:0] alu_in_2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_result;
    logic        alu_bcond;

    int n_vec = 0;
    int n_err = 0;

    multicycle_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .alu_in_1  (alu_in_1),
        .alu_in_2  (alu_in_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_result(alu_result),
        .alu_bcond (alu_bcond)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the op must produce and how many edges it takes.
    function automatic logic [32:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        bc;
        int          sh;
        sh = int'(b % 32);
        r  = 32'd0;
        bc = 1'b0;
        if (op == ALU_OP_ADD) r = a + b;
        else if (op == ALU_OP_SUB) r = a - b;
        else if (op == ALU_OP_SLL) r = a << sh;
        else if (op == ALU_OP_SRL) r = a >> sh;
        else if (op == ALU_OP_XOR) r = a ^ b;
        else if (op == ALU_OP_OR)  r = a | b;
        else if (op == ALU_OP_AND) r = a & b;
        else if (op >= ALU_OP_BEQ && op <= ALU_OP_BGE) begin
            r = a - b;
            if (op == ALU_OP_BEQ) bc = (a == b);
            if (op == ALU_OP_BNE) bc = (a != b);
            if (op == ALU_OP_BLT) bc = (int'(a) < int'(b));
            if (op == ALU_OP_BGE) bc = (int'(a) >= int'(b));
        end
        return {bc, r};
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
        return 1;
`else
        if ((op == ALU_OP_SLL || op == ALU_OP_SRL) && (b % 32) != 0) return int'(b % 32) + 1;
        return 1;
`endif
    endfunction

    // Model state, advanced on the same edges the DUT sees.
    int          cyc = 0;
    int          acc_cyc = 0;
    int          m_lat = 0;
    bit          m_busy = 1'b0;
    logic [31:0] m_res = '0;
    logic        m_bc = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy && (cyc - acc_cyc + 1 >= m_lat)) begin
                if (out_ready) m_busy = 1'b0;
            end else if (!m_busy && in_valid) begin
                logic [32:0] t;
                t       = ref_op(alu_op, alu_in_1, alu_in_2);
                m_res   = t[31:0];
                m_bc    = t[32];
                m_lat   = ref_latency(alu_op, alu_in_2);
                acc_cyc = cyc + 1;
                m_busy  = 1'b1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_busy) begin
            bit done;
            done = (cyc - acc_cyc + 1 >= m_lat);
            check("out_valid", {31'd0, out_valid}, {31'd0, done});
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (done) begin
                check("alu_result", alu_result, m_res);
                check("alu_bcond", {31'd0, alu_bcond}, {31'd0, m_bc});
            end
        end else begin
            check("out_valid_idle", {31'd0, out_valid}, 32'd0);
            check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        end
    end

    // Issue one op, optionally stall the consumer, return measured latency and outputs.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, output int lat, output logic [31:0] res, output logic bc);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = op;
        alu_in_1 = a;
        alu_in_2 = b;
        @(negedge clk);
        lat      = 1;
        alu_op   = 4'($urandom);
        alu_in_1 = $urandom;
        alu_in_2 = $urandom;
        in_valid = 1'($urandom);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            in_valid = 1'($urandom);
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
        res = alu_result;
        bc  = alu_bcond;
        repeat (stall) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        bc;
        int          serial_sll;

`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
        serial_sll = 1;
`else
        serial_sll = 32;
`endif

        #12;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", alu_result, 32'd0);
        check("reset_bcond", {31'd0, alu_bcond}, 32'd0);
        #3 reset = 1'b1;

        issue(ALU_OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, lat, res, bc);
        check("add_result", res, 32'h8000_0000);
        check("add_bcond", {31'd0, bc}, 32'd0);
        check("add_latency", lat, 32'd1);

        issue(ALU_OP_SLL, 32'h0000_0001, 32'h0000_001F, 0, lat, res, bc);
        check("sll31_result", res, 32'h8000_0000);
        check("sll31_latency", lat, serial_sll);

        issue(ALU_OP_BLT, 32'hFFFF_FFFF, 32'h0000_0001, 0, lat, res, bc);
        check("blt_bcond", {31'd0, bc}, 32'd1);
        check("blt_result", res, 32'hFFFF_FFFE);
        issue(ALU_OP_BGE, 32'hFFFF_FFFF, 32'h0000_0001, 0, lat, res, bc);
        check("bge_bcond", {31'd0, bc}, 32'd0);
        check("bge_result", res, 32'hFFFF_FFFE);
        issue(ALU_OP_BEQ, 32'h1234_5678, 32'h1234_5678, 0, lat, res, bc);
        check("beq_bcond", {31'd0, bc}, 32'd1);

        issue(ALU_OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5, lat, res, bc);
        check("xor_result", res, 32'h0F0F_F0F0);

        issue(4'hF, 32'hDEAD_BEEF, 32'h0000_0003, 0, lat, res, bc);
        check("unknown_result", res, 32'd0);
        check("unknown_bcond", {31'd0, bc}, 32'd0);
        check("unknown_latency", lat, 32'd1);
        issue(ALU_OP_SRL, 32'h1234_5678, 32'h0000_0000, 0, lat, res, bc);
        check("srl0_result", res, 32'h1234_5678);
        check("srl0_latency", lat, 32'd1);

        // Abort an SRL by 20 part-way through with reset, placed between clock edges.
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = ALU_OP_SRL;
        alu_in_1 = 32'hFFFF_FFFF;
        alu_in_2 = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", alu_result, 32'd0);
        check("abort_bcond", {31'd0, alu_bcond}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        issue(ALU_OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, lat, res, bc);
        check("and_after_reset", res, 32'h0F00_0F00);
        check("and_latency", lat, 32'd1);

        for (int i = 0; i < 250; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            issue(op, a, b, $urandom_range(0, 2), lat, res, bc);
            check("rand_latency", lat, ref_latency(op, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

- Iterative execute-stage ALU that sits directly downstream of the ALU control unit.
- Consumes the 4-bit `alu_op` and two 32-bit operands under a valid/ready handshake; returns a registered result and branch condition.
- Logical shifts run bit-serially, one position per cycle; all other operations complete in one cycle.
- Used by the multi-cycle datapath in place of the combinational ALU; the control FSM waits on `out_valid`.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_WIDTH`, default 5: shift-amount width; taken from `alu_in_2[SHAMT_WIDTH-1:0]`.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operation request.
- `in_ready` output, 1: the block can accept a request (IDLE only).
- `alu_op` input, 4: operation code from the ALU control unit (`alu_opcodes.v` encodings).
- `alu_in_1` input, DATA_WIDTH: operand 1 (rs1 or PC).
- `alu_in_2` input, DATA_WIDTH: operand 2 (rs2 or immediate).
- `out_valid` output, 1: result is valid and held.
- `out_ready` input, 1: consumer accepts the result.
- `alu_result` output, DATA_WIDTH: registered result.
- `alu_bcond` output, 1: registered branch-taken flag.

## Operation
- Has three states: IDLE, SHIFT and DONE. All outputs are 0 on reset, except `in_ready`, which is 1.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`, latch `alu_op`, both operands and shamt.
  - For non-shift ops, compute the result into the result register and go to DONE.
  - For SLL/SRL with shamt=0, result=`alu_in_1` and go to DONE.
  - For SLL/SRL with shamt>0, load `alu_in_1` into the result register, load the counter with shamt, and go to SHIFT.
- **SHIFT:**
  - Each cycle, shift the result register by 1 (SLL left, SRL logical right, zero fill) and decrement the counter.
  - Go to DONE on the cycle the counter reaches 0.
  - `in_valid` is ignored.
- **DONE:**
  - `out_valid`=1; `alu_result`/`alu_bcond` are held stable.
  - On `out_ready`, go to IDLE. `in_ready` is low in DONE, so there is no same-cycle accept.
- **Arithmetic:**
  - ADD/SUB: modulo 2^DATA_WIDTH; overflow is ignored.
  - XOR/OR/AND: bitwise.
  - `alu_bcond`=0 for all non-branch ops.
- **Branch ops:**
  - `alu_result` = `alu_in_1` - `alu_in_2`.
  - `alu_bcond`: BEQ → equal; BNE → not equal; BLT → signed less-than; BGE → signed greater-or-equal.
- **Unknown `alu_op`:** result 0, bcond 0, completes in one cycle. The block never hangs.
- **Reset mid-operation:** aborts immediately to IDLE. The result register, counter and `alu_bcond` clear to 0.

## Timing
- The request is accepted on the rising edge where `in_valid` and `in_ready` are both 1.
- **Non-shift ops and shamt=0:** `out_valid` rises 1 cycle after accept.
- **Shift with shamt n>0:** `out_valid` rises n+1 cycles after accept (n cycles in SHIFT). Maximum 32 cycles at shamt=31.
- **Back-to-back throughput:**
  - Result consumed in its first DONE cycle → next accept possible 2 cycles later (DONE→IDLE→accept).
  - Minimum issue interval is therefore 2 cycles for single-cycle ops.
- Inputs only need to be stable in the accept cycle; later changes have no effect.
- `out_valid` stays high indefinitely while `out_ready`=0.

## Configuration
- `MULTICYCLE_ALU_FAST_SHIFT_EN`:
  - Defined: SLL/SRL are computed by a combinational barrel shifter in IDLE and go straight to DONE. The latency for every op is 1, and the SHIFT state and counter are not built.
  - Undefined: bit-serial behaviour as above.
  - Results are identical in both builds; only latency differs.

## Structure
- Shared package/header `alu_opcodes.v`: all `alu_op` encodings (ADD, SUB, SLL, XOR, OR, AND, SRL, BEQ, BNE, BLT, BGE). No literals in this block.
- Local state encodings (IDLE/SHIFT/DONE) go in the same header as `ALU_ST_*` constants.
- Sub-module `alu_comb`: the combinational one-cycle datapath (arith/logic/compare, plus the barrel shifter when the macro is set). The top holds the FSM, counter and registers.

## Test plan
- **ADD:** 0x7FFFFFFF + 0x00000001 → `alu_result`=0x80000000, `alu_bcond`=0, `out_valid` 1 cycle after accept.
- **SLL:** 0x00000001 by `alu_in_2`=0x0000001F → 0x80000000. `out_valid` after 32 cycles serial, or 1 cycle with FAST_SHIFT_EN. `in_ready`=0 throughout.
- **Branches** with in1=0xFFFFFFFF, in2=0x00000001:
  - BLT → bcond=1; BGE → bcond=0; result=0xFFFFFFFE.
  - BEQ with equal operands → bcond=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after an XOR 0xF0F0F0F0^0xFFFF0000 → `alu_result`=0x0F0FF0F0 stable, and a new `in_valid` is ignored.
- **Reset mid-shift:** SRL by 20, then assert `reset` low at cycle 7 → outputs 0, `in_ready`=1 immediately. After release, an AND completes normally.
- **Unknown `alu_op` and shamt=0:** unused code → result 0, bcond 0, 1-cycle. SRL by 0 of 0x12345678 → 0x12345678, 1-cycle.
